// File: rtl/csa42_pkg.sv
// Shared types and helpers for the bit-serial 4:2 compressor adder controller.
// Optional CPA resolve phase is selected with CSA42_SERIAL_CPA_EN.
package csa42_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        CPA  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Ceiling log2; the controller sizes its bit counter with clog2(W+2).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder42.sv
// Radix-2 4:2 compressor cell: sum + 2*(carry + cout) = xin[0]+xin[1]+xin[2]+xin[3]+cin.
// cout depends only on xin[2:0], so it never ripples back from cin.
module adder42 (
    input  logic [3:0] xin,
    input  logic       cin,
    output logic       sum,
    output logic       carry,
    output logic       cout
);

    logic s1;

    assign s1    = xin[0] ^ xin[1] ^ xin[2];
    assign cout  = (xin[0] & xin[1]) | (xin[0] & xin[2]) | (xin[1] & xin[2]);
    assign sum   = s1 ^ xin[3] ^ cin;
    assign carry = (s1 & xin[3]) | (s1 & cin) | (xin[3] & cin);

endmodule

// File: rtl/csa42_serial_ctrl.sv
// Bit-serial four-operand adder: one adder42 cell builds a redundant S/C pair LSB-first,
// then (with CSA42_SERIAL_CPA_EN defined) reuses the same cell to resolve it to binary.
module csa42_serial_ctrl
    import csa42_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op0,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [W-1:0] op3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] out_s,
    output logic [W+1:0] out_c,
    output logic         busy
);

    localparam int CW = clog2(W + 2);
    localparam logic [CW-1:0] LAST_COMP = CW'(W);
`ifdef CSA42_SERIAL_CPA_EN
    localparam logic [CW-1:0] LAST_CPA  = CW'(W + 1);
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  sh0_q, sh1_q, sh2_q, sh3_q;
    logic [W+1:0]  s_q, c_q, s_next, c_next;
    logic [W+1:0]  out_s_q, out_c_q;
    logic          cout_r;
    logic [3:0]    xin;
    logic          cin;
    logic          add_sum, add_carry, add_cout;
`ifdef CSA42_SERIAL_CPA_EN
    logic [W+1:0]  r_q, r_next;
    logic          cy_r;
`endif

    adder42 u_adder42 (
        .xin   (xin),
        .cin   (cin),
        .sum   (add_sum),
        .carry (add_carry),
        .cout  (add_cout)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == COMP) || (state_q == CPA);
    assign out_s     = out_s_q;
    assign out_c     = out_c_q;

    // Next-state and the operand mux feeding the shared compressor cell.
    always_comb begin
        state_d = state_q;
        xin     = 4'b0000;
        cin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = COMP;
            end
            COMP: begin
                cin = cout_r;
                if (cnt_q != LAST_COMP) begin
                    xin = {sh3_q[0], sh2_q[0], sh1_q[0], sh0_q[0]};
                end else begin
`ifdef CSA42_SERIAL_CPA_EN
                    state_d = CPA;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CSA42_SERIAL_CPA_EN
            CPA: begin
                xin = {1'b0, cy_r, s_q[cnt_q], c_q[cnt_q]};
                if (cnt_q == LAST_CPA) state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Vectors as they will look after this cycle's bit is written.
    always_comb begin
        s_next = s_q;
        c_next = c_q;
        s_next[cnt_q]          = add_sum;
        c_next[cnt_q + 1'b1]   = add_carry;
`ifdef CSA42_SERIAL_CPA_EN
        r_next        = r_q;
        r_next[cnt_q] = add_sum;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            sh3_q   <= '0;
            s_q     <= '0;
            c_q     <= '0;
            cout_r  <= 1'b0;
            out_s_q <= '0;
            out_c_q <= '0;
`ifdef CSA42_SERIAL_CPA_EN
            r_q     <= '0;
            cy_r    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh0_q  <= op0;
                        sh1_q  <= op1;
                        sh2_q  <= op2;
                        sh3_q  <= op3;
                        s_q    <= '0;
                        c_q    <= '0;
                        cout_r <= 1'b0;
                        cnt_q  <= '0;
`ifdef CSA42_SERIAL_CPA_EN
                        r_q    <= '0;
                        cy_r   <= 1'b0;
`endif
                    end
                end
                COMP: begin
                    sh0_q  <= sh0_q >> 1;
                    sh1_q  <= sh1_q >> 1;
                    sh2_q  <= sh2_q >> 1;
                    sh3_q  <= sh3_q >> 1;
                    s_q    <= s_next;
                    c_q    <= c_next;
                    cout_r <= add_cout;
                    if (cnt_q == LAST_COMP) begin
                        cnt_q <= '0;
`ifndef CSA42_SERIAL_CPA_EN
                        out_s_q <= s_next;
                        out_c_q <= c_next;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef CSA42_SERIAL_CPA_EN
                // Only three cell inputs are live here, so carry and cout are never both set.
                CPA: begin
                    r_q  <= r_next;
                    cy_r <= add_carry | add_cout;
                    if (cnt_q == LAST_CPA) begin
                        cnt_q   <= '0;
                        out_s_q <= r_next;
                        out_c_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa42_serial_ctrl.sv
// Directed bench for csa42_serial_ctrl (W=8); expectations follow CSA42_SERIAL_CPA_EN.
module tb_csa42_serial_ctrl;

    localparam int W  = 8;
    localparam int SW = W + 2;
`ifdef CSA42_SERIAL_CPA_EN
    localparam int LAT = 2 * W + 3;
`else
    localparam int LAT = W + 1;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op0, op1, op2, op3;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_s;
    logic [SW-1:0] out_c;
    logic          busy;

    int checks;
    int passes;
    int fails;
    int accepted;
    int results;
    logic [SW-1:0] exp_q[$];

    csa42_serial_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op0       (op0),
        .op1       (op1),
        .op2       (op2),
        .op3       (op3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set; returns at the negedge after the accept edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
        @(negedge clk);
        op0 = a; op1 = b; op2 = c; op3 = d;
        in_valid = 1'b1;
        check("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(SW'(a) + SW'(b) + SW'(c) + SW'(d));
        accepted++;
        @(negedge clk);
        in_valid = 1'b0;
        op0 = W'($urandom); op1 = W'($urandom); op2 = W'($urandom); op3 = W'($urandom);
    endtask

    // Counts edges since accept until out_valid is seen, with a bound.
    task automatic wait_result(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic check_result(input string tag);
        logic [SW-1:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        results++;
`ifdef CSA42_SERIAL_CPA_EN
        check({tag, "_out_s"}, 32'(out_s), 32'(exp));
        check({tag, "_out_c"}, 32'(out_c), 32'd0);
`else
        check({tag, "_s_plus_c"}, 32'(out_s) + 32'(out_c), 32'(exp));
        check({tag, "_s_msb"}, 32'(out_s[SW-1]), 32'd0);
`endif
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [SW-1:0] held_s, held_c;
        logic [W-1:0] ra, rb, rc, rd;
        checks = 0; passes = 0; fails = 0; accepted = 0; results = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op0 = '0; op1 = '0; op2 = '0; op3 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_s", 32'(out_s), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
        rst = 1'b0;

        // 1+2+3+4 = 10
        accept(8'd1, 8'd2, 8'd3, 8'd4);
        check("t1_busy", 32'(busy), 32'd1);
        wait_result(0, lat);
        check("t1_latency", 32'(lat), 32'(LAT));
`ifndef CSA42_SERIAL_CPA_EN
        check("t1_pair_s", 32'(out_s), 32'h002);
        check("t1_pair_c", 32'(out_c), 32'h008);
`endif
        check_result("t1");
        release_result();

        // 255 x4 with in_valid pulses during COMP and DONE, plus 5-cycle backpressure
        accept(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        op0 = 8'd9; op1 = 8'd9; op2 = 8'd9; op3 = 8'd9;
        in_valid = 1'b1;
        check("t2_comp_in_ready", 32'(in_ready), 32'd0);
        check("t2_comp_busy", 32'(busy), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(3, lat);
        check("t2_latency", 32'(lat), 32'(LAT));
`ifdef CSA42_SERIAL_CPA_EN
        check("t2_out_s_3fc", 32'(out_s), 32'h3FC);
`else
        check("t2_pair_s", 32'(out_s), 32'h1FE);
        check("t2_pair_c", 32'(out_c), 32'h1FE);
`endif
        check_result("t2");
        held_s = out_s;
        held_c = out_c;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k == 1);
            check("t2_stall_valid", 32'(out_valid), 32'd1);
            check("t2_stall_s", 32'(out_s), 32'(held_s));
            check("t2_stall_c", 32'(out_c), 32'(held_c));
        end
        in_valid = 1'b0;
        release_result();

        // out_ready high from accept onward: no early effect, DONE lasts one cycle
        accept(8'd10, 8'd20, 8'd30, 8'd40);
        out_ready = 1'b1;
        wait_result(0, lat);
        check("t3_latency", 32'(lat), 32'(LAT));
        check_result("t3");
        @(negedge clk);
        out_ready = 1'b0;
        check("t3_out_valid_drop", 32'(out_valid), 32'd0);

        // Asynchronous reset while at bit 4 of COMP
        accept(8'd5, 8'd6, 8'd7, 8'd8);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_rst_in_ready", 32'(in_ready), 32'd1);
        check("t4_rst_out_valid", 32'(out_valid), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_out_s", 32'(out_s), 32'd0);
        check("t4_rst_out_c", 32'(out_c), 32'd0);
        void'(exp_q.pop_back());
        accepted--;
        @(negedge clk);
        rst = 1'b0;
        accept(8'd0, 8'd0, 8'd0, 8'd0);
        wait_result(0, lat);
        check("t4_latency", 32'(lat), 32'(LAT));
        check("t4_zero_s", 32'(out_s), 32'd0);
        check_result("t4");
        release_result();

        // Random sweep with random result stalls
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = W'($urandom_range(0, 255));
            rd = W'($urandom_range(0, 255));
            accept(ra, rb, rc, rd);
            wait_result(0, lat);
            check("rand_latency", 32'(lat), 32'(LAT));
            check_result("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end

        check("count_results", 32'(results), 32'(accepted));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
